// File: rtl/decode_stage.sv
// Registered RV32I decode stage between IFU and EXU; EBREAK parks the stage in a sticky HALT state.
// Optional M-extension MUL decode is enabled with `define DECODE_MEXT_EN. `type` is a keyword, so that field is dec_type.
module decode_stage #(
    parameter int XLEN   = 32,
    parameter int ALUC_W = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [XLEN-1:0]   pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [4:0]        rd,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [XLEN-1:0]   imm,
    output logic [2:0]        dec_type,
    output logic [ALUC_W-1:0] aluc,
    output logic              m1,
    output logic              rf_we,
    output logic              ebreak,
    output logic              illegal,
    output logic              halt,
    output logic [CNT_W-1:0]  dec_cnt,
    output logic [1:0]        dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready never looks at in_valid, and the output bundle is held while out_valid & ~out_ready.

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_HALT      = 2'd2
    } state_t;

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_R    = 3'd2;
    localparam logic [2:0] T_S    = 3'd3;
    localparam logic [2:0] T_B    = 3'd4;
    localparam logic [2:0] T_U    = 3'd5;
    localparam logic [2:0] T_J    = 3'd6;

    localparam logic [ALUC_W-1:0] ALU_ADD   = ALUC_W'(0);
    localparam logic [ALUC_W-1:0] ALU_SUB   = ALUC_W'(1);
    localparam logic [ALUC_W-1:0] ALU_SLL   = ALUC_W'(2);
    localparam logic [ALUC_W-1:0] ALU_SLT   = ALUC_W'(3);
    localparam logic [ALUC_W-1:0] ALU_SLTU  = ALUC_W'(4);
    localparam logic [ALUC_W-1:0] ALU_XOR   = ALUC_W'(5);
    localparam logic [ALUC_W-1:0] ALU_SRL   = ALUC_W'(6);
    localparam logic [ALUC_W-1:0] ALU_SRA   = ALUC_W'(7);
    localparam logic [ALUC_W-1:0] ALU_OR    = ALUC_W'(8);
    localparam logic [ALUC_W-1:0] ALU_AND   = ALUC_W'(9);
    localparam logic [ALUC_W-1:0] ALU_PASSB = ALUC_W'(10);
`ifdef DECODE_MEXT_EN
    localparam logic [ALUC_W-1:0] ALU_MUL   = ALUC_W'(11);
`endif

    state_t r_state;
    state_t w_state_nxt;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [4:0]        r_rd;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [XLEN-1:0]   r_imm;
    logic [2:0]        r_type;
    logic [ALUC_W-1:0] r_aluc;
    logic              r_m1;
    logic              r_rf_we;
    logic              r_ebreak;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_cnt;

    logic [6:0]        w_op;
    logic [2:0]        w_f3;
    logic [6:0]        w_f7;
    logic [ALUC_W-1:0] w_alu_f3;
    logic [2:0]        w_type;
    logic [ALUC_W-1:0] w_aluc;
    logic              w_m1;
    logic              w_wr;
    logic              w_ill;
    logic              w_ebk;
    logic [31:0]       w_imm32;
    logic [XLEN-1:0]   w_imm;
    logic              w_accept;
    logic              w_fire;

    assign w_op = inst[6:0];
    assign w_f3 = inst[14:12];
    assign w_f7 = inst[31:25];

    // funct3 -> ALU op shared by OP and OP-IMM (funct7 refinements applied below)
    always_comb begin
        w_alu_f3 = ALU_ADD;
        case (w_f3)
            3'b000:  w_alu_f3 = ALU_ADD;
            3'b001:  w_alu_f3 = ALU_SLL;
            3'b010:  w_alu_f3 = ALU_SLT;
            3'b011:  w_alu_f3 = ALU_SLTU;
            3'b100:  w_alu_f3 = ALU_XOR;
            3'b101:  w_alu_f3 = ALU_SRL;
            3'b110:  w_alu_f3 = ALU_OR;
            default: w_alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin
        w_type = T_NONE;
        w_aluc = ALU_ADD;
        w_m1   = 1'b1;
        w_wr   = 1'b0;
        w_ill  = 1'b0;
        w_ebk  = 1'b0;
        case (w_op)
            7'b0110111: begin w_type = T_U; w_aluc = ALU_PASSB; w_wr = 1'b1; end
            7'b0010111: begin w_type = T_U; w_wr = 1'b1; end
            7'b1101111: begin w_type = T_J; w_wr = 1'b1; end
            7'b1100111: begin w_type = T_I; w_wr = 1'b1; w_ill = (w_f3 != 3'b000); end
            7'b1100011: begin w_type = T_B; w_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011); end
            7'b0000011: begin
                w_type = T_I;
                w_wr   = 1'b1;
                w_ill  = !(w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            7'b0100011: begin w_type = T_S; w_ill = !(w_f3 inside {3'b000, 3'b001, 3'b010}); end
            7'b0010011: begin
                w_type = T_I;
                w_wr   = 1'b1;
                w_aluc = w_alu_f3;
                if (w_f3 == 3'b001) begin
                    w_ill = (w_f7 != 7'b0000000);
                end else if (w_f3 == 3'b101) begin
                    if (w_f7 == 7'b0100000) w_aluc = ALU_SRA;
                    else if (w_f7 != 7'b0000000) w_ill = 1'b1;
                end
            end
            7'b0110011: begin
                w_type = T_R;
                w_wr   = 1'b1;
                w_m1   = 1'b0;
                if (w_f7 == 7'b0000000) begin
                    w_aluc = w_alu_f3;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_aluc = ALU_SUB;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
                    w_aluc = ALU_SRA;
`ifdef DECODE_MEXT_EN
                end else if (w_f7 == 7'b0000001 && w_f3 == 3'b000) begin
                    w_aluc = ALU_MUL;
`endif
                end else begin
                    w_ill = 1'b1;
                end
            end
            // Only EBREAK is recognised in SYSTEM space; ECALL/CSR forms are flagged illegal
            7'b1110011: begin
                if (inst == 32'h0010_0073) w_ebk = 1'b1;
                else w_ill = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_type = T_NONE;
            w_aluc = ALU_ADD;
            w_m1   = 1'b1;
            w_wr   = 1'b0;
        end
    end

    always_comb begin
        w_imm32 = 32'd0;
        case (w_type)
            T_I:     w_imm32 = {{20{inst[31]}}, inst[31:20]};
            T_S:     w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            T_B:     w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            T_U:     w_imm32 = {inst[31:12], 12'd0};
            T_J:     w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    assign w_imm    = XLEN'($signed(w_imm32));
    assign in_ready = (r_state == ST_RUN) && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_fire   = r_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // Flush wins over everything; a flushed EBREAK never reaches HALT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:       if (!flush && w_accept && w_ebk) w_state_nxt = ST_HALT_PEND;
            ST_HALT_PEND: begin
                if (flush)       w_state_nxt = ST_RUN;
                else if (w_fire) w_state_nxt = ST_HALT;
            end
            ST_HALT:      w_state_nxt = ST_HALT;
            default:      w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_imm     <= '0;
            r_type    <= '0;
            r_aluc    <= '0;
            r_m1      <= 1'b0;
            r_rf_we   <= 1'b0;
            r_ebreak  <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid   <= 1'b1;
                r_pc      <= pc;
                r_rd      <= inst[11:7];
                r_rs1     <= inst[19:15];
                r_rs2     <= inst[24:20];
                r_imm     <= w_imm;
                r_type    <= w_type;
                r_aluc    <= w_aluc;
                r_m1      <= w_m1;
                r_rf_we   <= w_wr && (inst[11:7] != 5'd0);
                r_ebreak  <= w_ebk;
                r_illegal <= w_ill;
            end else if (w_fire) begin
                r_valid <= 1'b0;
            end
            if (!flush && w_fire && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_valid;
    assign out_pc    = r_pc;
    assign rd        = r_rd;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign imm       = r_imm;
    assign dec_type  = r_type;
    assign aluc      = r_aluc;
    assign m1        = r_m1;
    assign rf_we     = r_rf_we;
    assign ebreak    = r_ebreak;
    assign illegal   = r_illegal;
    assign halt      = (r_state == ST_HALT);
    assign dec_cnt   = r_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps plus random traffic against a queue-based reference model.
// Uses a 4-bit dec_cnt so counter saturation is reachable.
module tb_decode_stage;

    localparam int CNT_W = 4;
`ifdef DECODE_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic [3:0]  aluc;
        logic        m1;
        logic        rf_we;
        logic        ebreak;
        logic        illegal;
    } bundle_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [31:0]      pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;
    logic [2:0]       dec_type;
    logic [3:0]       aluc;
    logic             m1;
    logic             rf_we;
    logic             ebreak;
    logic             illegal;
    logic             halt;
    logic [CNT_W-1:0] dec_cnt;
    logic [1:0]       dbg_state;

    decode_stage #(.XLEN(32), .ALUC_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .dec_type(dec_type),
        .aluc(aluc), .m1(m1), .rf_we(rf_we), .ebreak(ebreak), .illegal(illegal),
        .halt(halt), .dec_cnt(dec_cnt), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    int      n_checks;
    int      n_errors;
    bundle_t exp_q[$];
    bit      m_halt;
    bit      m_pend;
    int      m_cnt;
    bit      m_rdy;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] p);
        bundle_t b;
        int      alu_tab[8];
        int      s;
        int      f3;
        int      f7;
        int      fmt;
        bit      legal;
        bit      wr;
        alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
        s   = int'(w);
        f3  = int'(w[14:12]);
        f7  = int'(w[31:25]);
        b   = '0;
        b.pc  = p;
        b.rd  = w[11:7];
        b.rs1 = w[19:15];
        b.rs2 = w[24:20];
        b.m1  = 1'b1;
        fmt   = 0;
        legal = 1'b1;
        wr    = 1'b1;
        case (w[6:0])
            7'h37: begin fmt = 5; b.aluc = 4'd10; end
            7'h17: fmt = 5;
            7'h6F: fmt = 6;
            7'h67: begin fmt = 1; legal = (f3 == 0); end
            7'h63: begin fmt = 4; wr = 1'b0; legal = !(f3 == 2 || f3 == 3); end
            7'h03: begin fmt = 1; legal = (f3 inside {0, 1, 2, 4, 5}); end
            7'h23: begin fmt = 3; wr = 1'b0; legal = (f3 < 3); end
            7'h13: begin
                fmt = 1;
                b.aluc = 4'(alu_tab[f3]);
                if (f3 == 1) legal = (f7 == 0);
                else if (f3 == 5) begin
                    legal = (f7 == 0 || f7 == 32);
                    if (f7 == 32) b.aluc = 4'd7;
                end
            end
            7'h33: begin
                fmt = 2;
                b.m1 = 1'b0;
                if (f7 == 0) b.aluc = 4'(alu_tab[f3]);
                else if (f7 == 32) begin
                    legal  = (f3 == 0 || f3 == 5);
                    b.aluc = (f3 == 0) ? 4'd1 : 4'd7;
                end else if (f7 == 1) begin
                    legal  = MEXT && (f3 == 0);
                    b.aluc = 4'd11;
                end else legal = 1'b0;
            end
            7'h73: begin wr = 1'b0; legal = (w == 32'h0010_0073); b.ebreak = legal; end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            b.illegal = 1'b1;
            fmt    = 0;
            b.aluc = 4'd0;
            b.m1   = 1'b1;
            wr     = 1'b0;
        end
        case (fmt)
            1: b.imm = 32'(s >>> 20);
            3: b.imm = 32'(((s >>> 25) << 5) | int'(w[11:7]));
            4: b.imm = 32'(((s >>> 31) << 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1));
            5: b.imm = w & 32'hFFFF_F000;
            6: b.imm = 32'(((s >>> 31) << 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1));
            default: b.imm = 32'd0;
        endcase
        b.typ   = 3'(fmt);
        b.rf_we = wr && (w[11:7] != 5'd0);
        return b;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops[11];
        logic [31:0] r;
        int          k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};
        r = $urandom();
        k = $urandom_range(0, 11);
        if (k < 11) begin
            r[6:0] = ops[k];
            if ((k == 7 || k == 8) && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 2))
                    0:       r[31:25] = 7'h00;
                    1:       r[31:25] = 7'h20;
                    default: r[31:25] = 7'h01;
                endcase
            end
        end
        if (r == 32'h0010_0073) r = 32'h0000_0013;
        return r;
    endfunction

    task automatic check_outputs();
        bundle_t got;
        m_rdy = !m_halt && !m_pend && (exp_q.size() == 0 || out_ready);
        chk("in_ready", 128'(in_ready), 128'(m_rdy));
        chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
        chk("halt", 128'(halt), 128'(m_halt));
        chk("dec_cnt", 128'(dec_cnt), 128'(m_cnt));
        if (exp_q.size() != 0) begin
            got = {out_pc, rd, rs1, rs2, imm, dec_type, aluc, m1, rf_we, ebreak, illegal};
            chk("bundle", 128'(got), 128'(exp_q[0]));
        end
    endtask

    task automatic model_update();
        bundle_t b;
        if (!rst_n) begin
            exp_q.delete();
            m_halt = 1'b0;
            m_pend = 1'b0;
            m_cnt  = 0;
        end else if (flush) begin
            exp_q.delete();
            m_pend = 1'b0;
        end else begin
            if (exp_q.size() != 0 && out_ready) begin
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (exp_q[0].ebreak) begin
                    m_halt = 1'b1;
                    m_pend = 1'b0;
                end
                void'(exp_q.pop_front());
            end
            if (in_valid && m_rdy) begin
                b = ref_decode(inst, pc);
                exp_q.push_back(b);
                if (b.ebreak) m_pend = 1'b1;
            end
        end
    endtask

    // driver: one clock cycle with the given inputs
    task automatic cycle(input logic r, input logic v, input logic [31:0] ins, input logic o, input logic f);
        @(negedge clk);
        rst_n     = r;
        in_valid  = v;
        inst      = ins;
        pc        = $urandom() & 32'hFFFF_FFFC;
        out_ready = o;
        flush     = f;
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_halt    = 1'b0;
        m_pend    = 1'b0;
        m_cnt     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        inst      = 32'd0;
        pc        = 32'd0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_halt", 128'(halt), 128'(0));
        chk("rst_dec_cnt", 128'(dec_cnt), 128'(0));
        chk("rst_fields", 128'({rd, rs1, rs2, imm, dec_type, aluc, m1, rf_we, ebreak, illegal}), 128'(0));

        // addi x1,x0,5
        cycle(1, 1, 32'h0050_0093, 1, 0);
        #1;
        chk("addi_valid", 128'(out_valid), 128'(1));
        chk("addi_fields", 128'({rd, rs1, imm, dec_type, aluc, m1, rf_we}),
            128'({5'd1, 5'd0, 32'd5, 3'd1, 4'd0, 1'b1, 1'b1}));
        cycle(1, 0, 32'd0, 1, 0);

        // two instructions under backpressure
        cycle(0, 0, 32'd0, 1, 0);
        cycle(1, 1, 32'h0020_81B3, 0, 0);
        cycle(1, 1, 32'h4020_81B3, 0, 0);
        #1;
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_held_aluc", 128'(aluc), 128'(0));
        cycle(1, 1, 32'h4020_81B3, 1, 0);
        #1;
        chk("bp_second_aluc", 128'(aluc), 128'(1));
        cycle(1, 0, 32'd0, 1, 0);
        #1;
        chk("bp_dec_cnt", 128'(dec_cnt), 128'(2));

        // sw x2,-4(x1)
        cycle(1, 1, 32'hFE20_AE23, 1, 0);
        #1;
        chk("sw_fields", 128'({dec_type, imm, rf_we, m1}), 128'({3'd3, 32'hFFFF_FFFC, 1'b0, 1'b1}));
        // all-zero word, then mul x3,x1,x2
        cycle(1, 1, 32'h0000_0000, 1, 0);
        #1;
        chk("zero_illegal", 128'({illegal, rf_we}), 128'({1'b1, 1'b0}));
        cycle(1, 1, 32'h0220_81B3, 1, 0);
        #1;
        chk("mul_decode", 128'({aluc, illegal}), MEXT ? 128'({4'd11, 1'b0}) : 128'({4'd0, 1'b1}));
        cycle(1, 0, 32'd0, 1, 0);

        // flush beats a simultaneous fire and accept
        cycle(1, 1, 32'h0050_0093, 0, 0);
        cycle(1, 1, 32'h0020_81B3, 1, 1);
        #1;
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_cnt", 128'(dec_cnt), 128'(5));

        // random traffic; the counter saturates along the way
        for (int i = 0; i < 400; i++) begin
            cycle(1, 1'($urandom_range(0, 1)), rand_inst(), 1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 19) == 0));
        end
        cycle(1, 0, 32'd0, 1, 0);
        #1;
        chk("cnt_saturated", 128'(dec_cnt), 128'((1 << CNT_W) - 1));

        // flushed EBREAK does not halt
        cycle(0, 0, 32'd0, 1, 0);
        cycle(1, 1, 32'h0010_0073, 0, 0);
        cycle(1, 1, 32'h0050_0093, 0, 0);
        cycle(1, 0, 32'd0, 1, 1);
        #1;
        chk("ebk_flush_halt", 128'(halt), 128'(0));
        chk("ebk_flush_ready", 128'(in_ready), 128'(1));

        // EBREAK consumed -> sticky halt
        cycle(1, 1, 32'h0010_0073, 0, 0);
        cycle(1, 1, 32'h0050_0093, 0, 0);
        #1;
        chk("ebk_flag", 128'(ebreak), 128'(1));
        cycle(1, 1, 32'h0050_0093, 1, 0);
        #1;
        chk("ebk_halt", 128'(halt), 128'(1));
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, rand_inst(), 1, 1'($urandom_range(0, 1)));
        end
        #1;
        chk("halt_sticky", 128'({halt, in_ready}), 128'({1'b1, 1'b0}));

        // reset while a bundle is in flight
        cycle(0, 0, 32'd0, 1, 0);
        cycle(1, 1, 32'h0050_0093, 0, 0);
        cycle(0, 0, 32'd0, 1, 0);
        #1;
        chk("midrst_state", 128'({out_valid, halt, dec_cnt}), 128'(0));
        cycle(1, 0, 32'd0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
